// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: two-port main-memory arbiter for an I-cache (port 0) and a
// D-cache (port 1), both using the picorv32 valid/ready handshake.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   p0_* / p1_*           requester side: valid, instr, addr, wdata, wstrb in;
//                         ready, rdata out (combinational from mem_ready/mem_rdata)
//   mem_*                 memory side: valid, instr, addr, wdata, wstrb out;
//                         ready, rdata in
//   grant_id              port that currently owns (or last owned) memory
//   busy                  high while a grant is outstanding (BUSY state)
//   timeout_err           sticky flag set when a grant is aborted on timeout
//   clear_err             clears timeout_err (a simultaneous set wins)
//
// Parameter TIMEOUT_CYCLES (>= 1): BUSY cycles a grant waits for mem_ready.
// Build option: define MEM_ARB_FIXED_PRIO_EN to make port 1 always win
// contention; otherwise arbitration is round-robin.

module mem_arbiter_2p #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_valid,
    input  logic        p0_instr,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wstrb,
    output logic        p0_ready,
    output logic [31:0] p0_rdata,

    input  logic        p1_valid,
    input  logic        p1_instr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wstrb,
    output logic        p1_ready,
    output logic [31:0] p1_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        grant_id,
    output logic        busy,
    output logic        timeout_err,
    input  logic        clear_err
);

    localparam int unsigned WAIT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_grant;
    logic                r_last_grant;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_err;
    logic                r_mem_valid;
    logic                r_mem_instr;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [3:0]          r_mem_wstrb;

    logic                w_req_any;
    logic                w_winner;
    logic                w_busy;
    logic                w_timeout_hit;
    logic                w_take;
    logic                w_done;
    logic                w_abort;
    logic                w_port_ready;
    logic [31:0]         w_port_rdata;

    // Winner selection among current requesters
    always_comb begin
        w_req_any = p0_valid | p1_valid;
`ifdef MEM_ARB_FIXED_PRIO_EN
        w_winner  = p1_valid;
`else
        w_winner  = (p0_valid & p1_valid) ? ~r_last_grant : p1_valid;
`endif
    end

    assign w_busy        = (r_state == ST_BUSY);
    // Last permitted wait cycle: the counter has counted TIMEOUT_CYCLES-1 misses
    assign w_timeout_hit = (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and transition strobes; mem_ready beats a same-cycle timeout
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else if (w_timeout_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, wait counter, grant history and sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_wait       <= '0;
            r_err        <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_instr  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
        end else begin
            if (w_take) begin
                r_grant     <= w_winner;
                r_mem_valid <= 1'b1;
                r_mem_instr <= w_winner ? p1_instr : p0_instr;
                r_mem_addr  <= w_winner ? p1_addr  : p0_addr;
                r_mem_wdata <= w_winner ? p1_wdata : p0_wdata;
                r_mem_wstrb <= w_winner ? p1_wstrb : p0_wstrb;
                r_wait      <= '0;
            end
            if (w_busy && !mem_ready) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (w_done || w_abort) begin
                r_mem_valid  <= 1'b0;
                r_last_grant <= r_grant;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end else if (clear_err) begin
                r_err <= 1'b0;
            end
        end
    end

    // Response steering; forced quiet while reset is held
    always_comb begin
        w_port_ready = 1'b0;
        w_port_rdata = '0;
        if (w_busy && reset) begin
            w_port_ready = mem_ready | w_abort;
            w_port_rdata = w_abort ? ABORT_RDATA : mem_rdata;
        end
    end

    assign p0_ready    = (r_grant == 1'b0) ? w_port_ready : 1'b0;
    assign p0_rdata    = (r_grant == 1'b0) ? w_port_rdata : 32'd0;
    assign p1_ready    = (r_grant == 1'b1) ? w_port_ready : 1'b0;
    assign p1_rdata    = (r_grant == 1'b1) ? w_port_rdata : 32'd0;

    assign mem_valid   = r_mem_valid;
    assign mem_instr   = r_mem_instr;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wstrb   = r_mem_wstrb;
    assign grant_id    = r_grant;
    assign busy        = w_busy;
    assign timeout_err = r_err;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p with TIMEOUT_CYCLES = 8.
module tb_mem_arbiter_2p;

    logic        clk;
    logic        reset;
    logic        p0_valid, p0_instr, p0_ready;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [3:0]  p0_wstrb;
    logic        p1_valid, p1_instr, p1_ready;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p1_wstrb;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        grant_id, busy, timeout_err, clear_err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter_2p #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .p0_valid   (p0_valid),
        .p0_instr   (p0_instr),
        .p0_addr    (p0_addr),
        .p0_wdata   (p0_wdata),
        .p0_wstrb   (p0_wstrb),
        .p0_ready   (p0_ready),
        .p0_rdata   (p0_rdata),
        .p1_valid   (p1_valid),
        .p1_instr   (p1_instr),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .p1_wstrb   (p1_wstrb),
        .p1_ready   (p1_ready),
        .p1_rdata   (p1_rdata),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err),
        .clear_err  (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        logic exp_port;
        logic rdy_got, rdy_other;
        logic [31:0] rd_got;

        reset = 1'b0; clear_err = 1'b0;
        p0_valid = 1'b0; p0_instr = 1'b0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
        p1_valid = 1'b0; p1_instr = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        check("rst_p0_ready", 32'(p0_ready), 32'd0);
        reset = 1'b1;

        // p0 instruction read at 0x100, ready on third BUSY cycle
        p0_valid = 1'b1; p0_instr = 1'b1; p0_addr = 32'h100; p0_wstrb = 4'h0;
        #1 check("t1_req_cycle_mem_valid", 32'(mem_valid), 32'd0);
        @(negedge clk);
        check("t1_mem_valid", 32'(mem_valid), 32'd1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_mem_instr", 32'(mem_instr), 32'd1);
        check("t1_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("t1_grant", 32'(grant_id), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_p0_ready_wait", 32'(p0_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        check("t1_p0_ready", 32'(p0_ready), 32'd1);
        check("t1_p0_rdata", p0_rdata, 32'hCAFE_0001);
        check("t1_p1_ready", 32'(p1_ready), 32'd0);
        check("t1_p1_rdata", p1_rdata, 32'd0);
        @(negedge clk);
        p0_valid = 1'b0; p0_instr = 1'b0;
        #1;
        check("t1_rel_p0_ready", 32'(p0_ready), 32'd0);
        check("t1_rel_mem_valid", 32'(mem_valid), 32'd0);
        check("t1_rel_busy", 32'(busy), 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        check("t1_idle_mem_valid", 32'(mem_valid), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Contention straight after reset
        reset = 1'b0;
        p0_valid = 1'b1; p0_addr = 32'h100;
        p1_valid = 1'b1; p1_addr = 32'h200; p1_wstrb = 4'h0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_port = 1'b1;
`else
            exp_port = (i % 2 == 1);
`endif
            check($sformatf("t2_grant_%0d", i), 32'(grant_id), 32'(exp_port));
            check($sformatf("t2_addr_%0d", i), mem_addr, exp_port ? 32'h200 : 32'h100);
            check($sformatf("t2_busy_%0d", i), 32'(busy), 32'd1);
            mem_ready = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i);
            #1;
            rdy_got   = exp_port ? p1_ready : p0_ready;
            rdy_other = exp_port ? p0_ready : p1_ready;
            rd_got    = exp_port ? p1_rdata : p0_rdata;
            check($sformatf("t2_ready_%0d", i), 32'(rdy_got), 32'd1);
            check($sformatf("t2_other_ready_%0d", i), 32'(rdy_other), 32'd0);
            check($sformatf("t2_rdata_%0d", i), rd_got, 32'hA000_0000 + 32'(i));
            @(negedge clk);
            mem_ready = 1'b0;
            check($sformatf("t2_rel_busy_%0d", i), 32'(busy), 32'd0);
            @(negedge clk);
            check($sformatf("t2_idle_mem_valid_%0d", i), 32'(mem_valid), 32'd0);
            if (i == 3) begin
                p0_valid = 1'b0; p1_valid = 1'b0;
            end
            @(negedge clk);
            check($sformatf("t2_next_busy_%0d", i), 32'(busy), (i < 3) ? 32'd1 : 32'd0);
        end

        // p1 write never acknowledged: aborted on the 8th BUSY cycle
        p1_valid = 1'b1; p1_addr = 32'h200; p1_wdata = 32'h1234_5678; p1_wstrb = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) p1_valid = 1'b0;
            #1;
            if (k == 1) begin
                check("t3_grant", 32'(grant_id), 32'd1);
                check("t3_wdata", mem_wdata, 32'h1234_5678);
                check("t3_wstrb", 32'(mem_wstrb), 32'hF);
            end
            if (k == 7) check("t3_addr_held", mem_addr, 32'h200);
            check($sformatf("t3_p1_ready_c%0d", k), 32'(p1_ready), (k == 8) ? 32'd1 : 32'd0);
            if (k == 8) begin
                check("t3_p1_rdata", p1_rdata, 32'hDEAD_BEEF);
                check("t3_p0_ready", 32'(p0_ready), 32'd0);
                check("t3_err_before", 32'(timeout_err), 32'd0);
            end
        end
        @(negedge clk);
        check("t3_err_set", 32'(timeout_err), 32'd1);
        check("t3_rel_busy", 32'(busy), 32'd0);
        check("t3_rel_mem_valid", 32'(mem_valid), 32'd0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("t3_err_cleared", 32'(timeout_err), 32'd0);

        // mem_ready on the last permitted wait cycle completes normally
        p0_valid = 1'b1; p0_addr = 32'h300; p0_wstrb = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) p0_valid = 1'b0;
            if (k == 8) begin
                mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
            end
            #1;
            if (k == 8) begin
                check("t4_p0_ready", 32'(p0_ready), 32'd1);
                check("t4_p0_rdata", p0_rdata, 32'h5555_AAAA);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        check("t4_err", 32'(timeout_err), 32'd0);
        check("t4_rel_busy", 32'(busy), 32'd0);

        // Timeout set and clear_err in the same cycle: set wins
        @(negedge clk);
        p1_valid = 1'b1; p1_addr = 32'h240; p1_wstrb = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) p1_valid = 1'b0;
            if (k == 8) clear_err = 1'b1;
        end
        @(negedge clk);
        clear_err = 1'b0;
        check("t5_set_beats_clear", 32'(timeout_err), 32'd1);
        @(negedge clk);

        // Reset asserted mid-BUSY, then a fresh p1 request
        p1_valid = 1'b1; p1_addr = 32'h400; p1_wstrb = 4'h0;
        @(negedge clk);
        check("t6_grant_pre", 32'(grant_id), 32'd1);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
        #1;
        check("t6_rst_p1_ready", 32'(p1_ready), 32'd0);
        check("t6_rst_p1_rdata", p1_rdata, 32'd0);
        @(negedge clk);
        check("t6_mem_valid", 32'(mem_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_grant", 32'(grant_id), 32'd0);
        check("t6_err", 32'(timeout_err), 32'd0);
        check("t6_mem_addr", mem_addr, 32'd0);
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        check("t6_re_busy", 32'(busy), 32'd1);
        check("t6_re_grant", 32'(grant_id), 32'd1);
        check("t6_re_addr", mem_addr, 32'h400);
        mem_ready = 1'b1; mem_rdata = 32'h600D_F00D;
        #1;
        check("t6_re_p1_ready", 32'(p1_ready), 32'd1);
        check("t6_re_p1_rdata", p1_rdata, 32'h600D_F00D);
        @(negedge clk);
        mem_ready = 1'b0; p1_valid = 1'b0;
        check("t6_re_rel_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
